// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill controller: FSM states and default sizes.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned VALUE_WIDTH = 32;
    localparam int unsigned TAG_WIDTH   = 2;
    localparam int unsigned WORD_OFFSET = 2;
    localparam int unsigned MEM_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        HIT_DATA,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        INVAL,
        RESP
    } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable cycle counter bounding the wait for a memory response.
module mem_timeout_ctr #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the enabled cycle whose increment reaches MEM_TIMEOUT, so the wait lasts exactly MEM_TIMEOUT cycles.
    assign expired_o = en_i && !clr_i && (count_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Load/store front end for the 4-line cache: probe, miss fill, write-through with allocate.
module cache_fill_ctrl #(
    parameter int unsigned ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter int unsigned VALUE_WIDTH = cache_pkg::VALUE_WIDTH,
    parameter int unsigned TAG_WIDTH   = cache_pkg::TAG_WIDTH,
    parameter int unsigned MEM_TIMEOUT = cache_pkg::MEM_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [VALUE_WIDTH-1:0] req_wdata,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic [VALUE_WIDTH-1:0] resp_data,
    output logic                   resp_err,
    output logic [TAG_WIDTH-1:0]   cache_tag,
    output logic [VALUE_WIDTH-1:0] cache_value,
    output logic                   cache_RD_,
    output logic                   cache_WR_,
    output logic                   cache_invalidate,
    input  logic                   cache_miss,
    input  logic [VALUE_WIDTH-1:0] cache_rdata,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [VALUE_WIDTH-1:0] mem_wdata,
    input  logic                   mem_rsp_valid,
    input  logic [VALUE_WIDTH-1:0] mem_rdata,
    input  logic                   mem_rsp_err
);

    import cache_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'((1 << WORD_OFFSET) - 1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [VALUE_WIDTH-1:0] wdata_q;
    logic [VALUE_WIDTH-1:0] rdata_q;
    logic                   write_q;
    logic                   err_q;

    logic ctr_clr;
    logic ctr_en;
    logic ctr_expired;

    mem_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clr_i    (ctr_clr),
        .en_i     (ctr_en),
        .expired_o(ctr_expired)
    );

    assign cache_tag = addr_q[WORD_OFFSET +: TAG_WIDTH];
    assign mem_addr  = addr_q & WORD_MASK;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_data        = '0;
        resp_err         = 1'b0;
        cache_value      = '0;
        cache_RD_        = 1'b1;
        cache_WR_        = 1'b1;
        cache_invalidate = 1'b0;
        mem_req_valid    = 1'b0;
        mem_we           = 1'b0;
        ctr_clr          = 1'b0;
        ctr_en           = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_write ? MEM_REQ : LOOKUP;
                end
            end
            LOOKUP: begin
                cache_RD_ = 1'b0;
                state_d   = cache_miss ? MEM_REQ : HIT_DATA;
            end
            HIT_DATA: begin
                state_d = RESP;
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_we        = write_q;
                ctr_clr       = 1'b1;
                if (mem_req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                ctr_en = 1'b1;
                // A response on the expiry cycle takes precedence over the timeout.
                if (mem_rsp_valid) begin
                    state_d = mem_rsp_err ? INVAL : FILL;
                end else if (ctr_expired) begin
                    state_d = INVAL;
                end
            end
            FILL: begin
                cache_WR_   = 1'b0;
                cache_value = write_q ? wdata_q : rdata_q;
                state_d     = RESP;
            end
            INVAL: begin
                cache_invalidate = 1'b1;
                state_d          = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = rdata_q;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // rdata_q only ever holds load data, so stores and errors respond with zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (state_q == HIT_DATA) begin
                rdata_q <= cache_rdata;
            end
            if (state_q == MEM_WAIT) begin
                if (mem_rsp_valid && !mem_rsp_err) begin
                    if (!write_q) begin
                        rdata_q <= mem_rdata;
                    end
                end else if (mem_rsp_valid || ctr_expired) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed table, reset corner case and randomized traffic.
module tb_cache_fill_ctrl;

    localparam int T = 4;

    logic        clk;
    logic        rst;
    logic        req_valid, req_write, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [1:0]  cache_tag;
    logic [31:0] cache_value, cache_rdata;
    logic        cache_RD_, cache_WR_, cache_invalidate, cache_miss;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rsp_valid, mem_rsp_err;

    cache_fill_ctrl #(
        .ADDR_WIDTH (32),
        .VALUE_WIDTH(32),
        .TAG_WIDTH  (2),
        .MEM_TIMEOUT(T)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .cache_tag       (cache_tag),
        .cache_value     (cache_value),
        .cache_RD_       (cache_RD_),
        .cache_WR_       (cache_WR_),
        .cache_invalidate(cache_invalidate),
        .cache_miss      (cache_miss),
        .cache_rdata     (cache_rdata),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rdata       (mem_rdata),
        .mem_rsp_err     (mem_rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total;
    int bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Environment cache: tag-indexed lines, read buffer valid the cycle after cache_RD_.
    logic [31:0] cdata [4];
    logic        cvalid [4];
    logic [31:0] crdata;
    assign cache_miss  = !cvalid[cache_tag];
    assign cache_rdata = crdata;

    initial begin
        for (int i = 0; i < 4; i++) begin
            cvalid[i] <= 1'b0;
            cdata[i]  <= '0;
        end
        cvalid[1] <= 1'b1;
        cdata[1]  <= 32'hDEADBEEF;
        crdata    <= '0;
        forever begin
            @(posedge clk);
            if (!cache_RD_) crdata <= cdata[cache_tag];
            if (!cache_WR_) begin
                cvalid[cache_tag] <= 1'b1;
                cdata[cache_tag]  <= cache_value;
            end
            if (cache_invalidate) cvalid[cache_tag] <= 1'b0;
        end
    end

    // Environment memory with configurable ready stall, response delay and error.
    logic [31:0] memarr [int];
    int          cfg_stall, cfg_delay;
    logic        cfg_err;
    logic        inject_late;
    int          req_cnt, stab_bad, excl_bad;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_we;

    function automatic logic [31:0] mem_word(input int w);
        if (memarr.exists(w)) return memarr[w];
        return (32'(w) * 32'h01000193) ^ 32'h5A5A0000;
    endfunction

    initial begin : mem_model
        int          stall_cnt, wait_cnt;
        logic        pend, perr, pw;
        int          pa;
        logic [31:0] pwd, f_addr, f_wdata;
        logic        f_we;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rdata     = '0;
        req_cnt = 0; stab_bad = 0;
        seen_addr = '0; seen_wdata = '0; seen_we = 1'b0;
        memarr[2] = 32'h12345678;
        memarr[5] = 32'hCAFEF00D;
        stall_cnt = 0; wait_cnt = 0; pend = 1'b0; perr = 1'b0; pw = 1'b0; pa = 0;
        pwd = '0; f_addr = '0; f_wdata = '0; f_we = 1'b0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            mem_rdata     = $urandom;
            mem_req_ready = 1'b0;
            if (!rst) begin
                pend = 1'b0;
                stall_cnt = 0;
            end else begin
                if (inject_late) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = 32'hBAD0BAD0;
                end else if (pend) begin
                    if (wait_cnt == 0) begin
                        pend = 1'b0;
                        mem_rsp_valid = 1'b1;
                        mem_rsp_err   = perr;
                        if (!perr) begin
                            if (pw) memarr[pa] = pwd;
                            else mem_rdata = mem_word(pa);
                        end
                    end else begin
                        wait_cnt--;
                    end
                end
                if (mem_req_valid && !pend) begin
                    if (stall_cnt == 0) begin
                        f_addr = mem_addr; f_wdata = mem_wdata; f_we = mem_we;
                    end else if (mem_addr !== f_addr || mem_wdata !== f_wdata || mem_we !== f_we) begin
                        stab_bad++;
                    end
                    if (stall_cnt < cfg_stall) begin
                        stall_cnt++;
                    end else begin
                        mem_req_ready = 1'b1;
                        stall_cnt = 0;
                        pend = (cfg_delay < T);
                        wait_cnt = cfg_delay;
                        perr = cfg_err;
                        pa = int'(mem_addr >> 2);
                        pw = mem_we;
                        pwd = mem_wdata;
                        req_cnt++;
                        seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
                    end
                end
            end
        end
    end

    initial begin : excl_monitor
        int n;
        excl_bad = 0;
        forever begin
            @(negedge clk);
            n = int'(!cache_RD_) + int'(!cache_WR_) + int'(cache_invalidate);
            if (n > 1) excl_bad++;
        end
    end

    // Reference model state: what the cache should hold after each completed request.
    logic [31:0] ref_data [4];
    logic        ref_valid [4];

    task automatic check_idle_outputs(input string name);
        chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({name, ".resp_valid"}, 32'(resp_valid), 32'd0);
        chk({name, ".resp_err"}, 32'(resp_err), 32'd0);
        chk({name, ".resp_data"}, resp_data, 32'd0);
        chk({name, ".mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({name, ".strobes"}, {29'd0, cache_RD_, cache_WR_, cache_invalidate}, 32'd6);
    endtask

    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall, input int delay,
                           input logic err, input logic use_tbl, input logic [31:0] t_data,
                           input logic t_err, input int t_lat);
        int          tag, d_eff, exp_lat, lat, req0, stab0, excl0, mism;
        logic        hit, responds, exp_err, exp_mem, got;
        logic [31:0] exp_data;
        tag = int'(addr[3:2]);
        hit = !wr && ref_valid[tag];
        if (hit) begin
            exp_data = ref_data[tag]; exp_err = 1'b0; exp_lat = 3; exp_mem = 1'b0;
        end else begin
            responds = (delay < T);
            d_eff    = responds ? delay : T - 1;
            exp_err  = !responds || err;
            exp_lat  = (wr ? 0 : 1) + 4 + stall + d_eff;
            exp_mem  = 1'b1;
            if (exp_err) begin
                ref_valid[tag] = 1'b0; exp_data = '0;
            end else if (wr) begin
                ref_valid[tag] = 1'b1; ref_data[tag] = wdata; exp_data = '0;
            end else begin
                exp_data = mem_word(int'(addr >> 2));
                ref_valid[tag] = 1'b1; ref_data[tag] = exp_data;
            end
        end
        if (use_tbl) begin
            exp_data = t_data; exp_err = t_err; exp_lat = t_lat;
        end
        cfg_stall = stall; cfg_delay = delay; cfg_err = err;
        req0 = req_cnt; stab0 = stab_bad; excl0 = excl_bad;
        @(negedge clk);
        chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 60; c++) begin
            if (resp_valid) begin
                lat = c; got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, ".resp_seen"}, 32'(got), 32'd1);
        chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({name, ".data"}, resp_data, exp_data);
        chk({name, ".err"}, 32'(resp_err), 32'(exp_err));
        chk({name, ".mem_reqs"}, 32'(req_cnt - req0), 32'(exp_mem));
        if (exp_mem) begin
            chk({name, ".mem_addr"}, seen_addr, addr & 32'hFFFF_FFFC);
            chk({name, ".mem_we"}, 32'(seen_we), 32'(wr));
            if (wr) chk({name, ".mem_wdata"}, seen_wdata, wdata);
        end
        chk({name, ".stable"}, 32'(stab_bad - stab0), 32'd0);
        chk({name, ".exclusive"}, 32'(excl_bad - excl0), 32'd0);
        mism = 0;
        for (int i = 0; i < 4; i++) begin
            if (cvalid[i] !== ref_valid[i]) mism++;
            else if (ref_valid[i] && cdata[i] !== ref_data[i]) mism++;
        end
        chk({name, ".cache"}, 32'(mism), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        int          delay;
        logic        err;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int   got;
        int   odd;
        logic wr, err;
        int   stall, delay;
        total = 0; bad = 0;
        inject_late = 1'b0;
        cfg_stall = 0; cfg_delay = 0; cfg_err = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            ref_valid[i] = 1'b0; ref_data[i] = '0;
        end
        ref_valid[1] = 1'b1; ref_data[1] = 32'hDEADBEEF;

        //            wr    addr   wdata         stall dly err  exp_data       err  lat
        tbl[0]  = '{1'b0, 32'h04, 32'h0,        0, 0,  1'b0, 32'hDEADBEEF, 1'b0, 3};
        tbl[1]  = '{1'b0, 32'h08, 32'h0,        0, 0,  1'b0, 32'h12345678, 1'b0, 5};
        tbl[2]  = '{1'b0, 32'h08, 32'h0,        0, 0,  1'b0, 32'h12345678, 1'b0, 3};
        tbl[3]  = '{1'b1, 32'h0C, 32'hA5A5A5A5, 0, 0,  1'b0, 32'h0,        1'b0, 4};
        tbl[4]  = '{1'b0, 32'h0C, 32'h0,        0, 0,  1'b0, 32'hA5A5A5A5, 1'b0, 3};
        tbl[5]  = '{1'b1, 32'h10, 32'h11112222, 3, 0,  1'b0, 32'h0,        1'b0, 7};
        tbl[6]  = '{1'b1, 32'h04, 32'h00000055, 0, 1,  1'b1, 32'h0,        1'b1, 5};
        tbl[7]  = '{1'b0, 32'h14, 32'h0,        0, 2,  1'b0, 32'hCAFEF00D, 1'b0, 7};
        tbl[8]  = '{1'b1, 32'h08, 32'h00000077, 0, 99, 1'b0, 32'h0,        1'b1, 7};
        tbl[9]  = '{1'b0, 32'h0A, 32'h0,        0, 3,  1'b0, 32'h12345678, 1'b0, 8};
        tbl[10] = '{1'b0, 32'h13, 32'h0,        0, 0,  1'b0, 32'h11112222, 1'b0, 3};
        tbl[11] = '{1'b1, 32'h0C, 32'h00000099, 0, 0,  1'b1, 32'h0,        1'b1, 4};
        tbl[12] = '{1'b0, 32'h0C, 32'h0,        0, 0,  1'b1, 32'h0,        1'b1, 5};

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_txn($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].stall,
                    tbl[i].delay, tbl[i].err, 1'b1, tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_lat);
        end

        // Abort a read miss while it waits on memory, then check a stray response is ignored.
        cfg_stall = 0; cfg_delay = 99; cfg_err = 1'b0;
        got = req_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1C; req_wdata = '0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 10 && req_cnt == got; c++) @(negedge clk);
        chk("rmid.mem_req", 32'(req_cnt - got), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_idle_outputs("rmid.async");
        @(negedge clk);
        rst = 1'b1;
        #1 inject_late = 1'b1;
        @(negedge clk);
        #1 inject_late = 1'b0;
        odd = 0;
        for (int c = 0; c < 3; c++) begin
            if (resp_valid || !req_ready || mem_req_valid || !cache_WR_ || cache_invalidate) odd++;
            @(negedge clk);
        end
        chk("rmid.late_rsp_ignored", 32'(odd), 32'd0);
        run_txn("rmid.next", 1'b0, 32'h1C, 32'h0, 0, 1, 1'b0, 1'b0, '0, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            wr    = 1'($urandom_range(0, 1));
            stall = int'($urandom_range(0, 2));
            delay = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 4));
            err   = ($urandom_range(0, 7) == 0);
            run_txn($sformatf("rnd%0d", i), wr, 32'($urandom_range(0, 63)), $urandom, stall,
                    delay, err, 1'b0, '0, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Sits between the IF/MEM pipeline stage and the 4-line LRU cache, with a path to next-level memory.
- Accepts one load/store request at a time and probes the cache.
- On a read miss, fetches the word from memory, fills the cache, then returns the data.
- Stores are write-through with write-allocate; a memory error or timeout invalidates the stale cache line.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- VALUE_WIDTH, 32, data word width.
- TAG_WIDTH, 2, cache tag width; tag = req_addr[TAG_WIDTH+1:2].
- MEM_TIMEOUT, 255, maximum cycles in MEM_WAIT before aborting with error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline request valid.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- req_wdata  in  VALUE_WIDTH  store data.
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  VALUE_WIDTH  load data; 0 for stores and errors.
- resp_err  out  1  memory error or timeout; qualified by resp_valid.
- cache_tag  out  TAG_WIDTH  tag presented to the cache.
- cache_value  out  VALUE_WIDTH  fill/update value.
- cache_RD_  out  1  active-low read strobe.
- cache_WR_  out  1  active-low write strobe.
- cache_invalidate  out  1  active-high line invalidate.
- cache_miss  in  1  combinational miss flag for cache_tag.
- cache_rdata  in  VALUE_WIDTH  cache read buffer, valid the cycle after cache_RD_ low.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  VALUE_WIDTH  memory write data.
- mem_rsp_valid  in  1  memory response valid.
- mem_rdata  in  VALUE_WIDTH  memory read data.
- mem_rsp_err  in  1  memory response error.

Behaviour:
- Reset (async, rst low) or reset mid-operation:
  - state returns to IDLE; latched address, data and timeout counter cleared.
  - req_ready=1; resp_valid=0, resp_err=0, resp_data=0.
  - mem_req_valid=0, cache_RD_=1, cache_WR_=1, cache_invalidate=0.
- Request latching: addr, wdata and write flag are captured on acceptance and held until RESP. cache_tag and mem_addr are driven from the latched address.
- State transitions:
  - IDLE: accepted read -> LOOKUP; accepted write -> MEM_REQ.
  - LOOKUP (1 cycle): cache_RD_=0; sample cache_miss. Hit -> HIT_DATA; miss -> MEM_REQ.
  - HIT_DATA (1 cycle): capture cache_rdata -> RESP.
  - MEM_REQ: mem_req_valid=1, mem_we=write flag, mem_wdata=latched wdata. Address and data are held stable until mem_req_ready is sampled high, then -> MEM_WAIT with the counter cleared.
  - MEM_WAIT: counter increments each cycle.
    - mem_rsp_valid & !mem_rsp_err -> FILL (read captures mem_rdata).
    - mem_rsp_valid & mem_rsp_err -> INVAL.
    - counter == MEM_TIMEOUT with no response -> INVAL.
    - A response arriving on the same cycle as timeout wins.
  - FILL (1 cycle): cache_WR_=0, cache_value = mem_rdata (read) or wdata (write) -> RESP.
  - INVAL (1 cycle): cache_invalidate=1 for the latched tag; error flag set -> RESP.
  - RESP (1 cycle): resp_valid=1 with resp_data/resp_err -> IDLE. The consumer must accept; there is no back-pressure.
- Signal qualification: mem_rsp_valid outside MEM_WAIT is ignored; cache_miss is ignored outside LOOKUP.
- Memory may not respond after a timeout.
- Strobe exclusivity: at most one of cache_RD_ low, cache_WR_ low, cache_invalidate high in any cycle.
- Latency, counted from the acceptance cycle, with mem_req_ready=1 and the response one cycle after the request:
  - read hit: resp_valid at +3.
  - read miss: resp_valid at +5.
  - write: resp_valid at +4.
- Back-to-back requests: req_ready rises the cycle after RESP, so there is one IDLE cycle minimum between requests.

Decomposition:
- Shared package cache_pkg holds the state enum (IDLE, LOOKUP, HIT_DATA, MEM_REQ, MEM_WAIT, FILL, INVAL, RESP), TAG_WIDTH, VALUE_WIDTH, WORD_OFFSET=2, and the default MEM_TIMEOUT.
- One sub-module, mem_timeout_ctr: clear/enable counter of width $clog2(MEM_TIMEOUT+1) with an expired flag.

Test Plan:
- Read hit: preload tag 1 = 0xDEADBEEF; read addr 0x4 -> cache_RD_ low at +1, resp_valid at +3, resp_data=0xDEADBEEF, no mem_req_valid.
- Read miss: empty cache, read addr 0x8, mem returns 0x12345678 -> mem_addr=0x8, cache_WR_ low with cache_tag=2 and cache_value=0x12345678, resp_valid at +5 with data 0x12345678.
- Memory stall: mem_req_ready low for 3 cycles -> mem_req_valid, mem_addr and mem_wdata stable throughout; response follows normally.
- Write: store 0xA5A5A5A5 to 0xC -> mem_we=1, mem_wdata=0xA5A5A5A5; after OK response, cache_WR_ low with tag 3; resp_valid, resp_err=0, resp_data=0.
- Error/timeout: mem_rsp_err=1 on a write -> cache_invalidate pulse on tag of the address, resp_err=1. With no response and MEM_TIMEOUT=4 -> INVAL after 4 MEM_WAIT cycles, resp_err=1.
- Reset mid-MEM_WAIT: drop rst -> outputs return to their reset values immediately (asynchronously); a late mem_rsp_valid afterwards is ignored; the next read proceeds normally.
